// File: rtl/perfect_sweep_sched.sv
// Sweep controller for the perfect-number checker: issues N = max(lo,2)..hi one
// at a time, waits for each completion, tallies perfect results and flags timeouts.
module perfect_sweep_sched #(
    parameter int W   = 8,
    parameter int TMO = 1023
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic [W-1:0] chk_n,
    output logic         chk_go,
    input  logic         chk_done,
    input  logic         chk_perfect,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] found_cnt,
    output logic [W-1:0] last_found
);

    localparam int TW = $clog2(TMO + 1);
    localparam logic [W-1:0]  TWO_W    = W'(32'd2);
    localparam logic [W-1:0]  ONE_W    = W'(32'd1);
    localparam logic [W-1:0]  MAX_W    = {W{1'b1}};
    localparam logic [TW-1:0] ONE_T    = TW'(32'd1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  cur_q, cur_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [W-1:0]  chk_n_q, chk_n_d;
    logic          chk_go_q, chk_go_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [W-1:0]  found_q, found_d;
    logic [W-1:0]  last_q, last_d;
    logic [W-1:0]  lo_clamp_s;

    // Next-state and registered-output computation
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        hi_d     = hi_q;
        timer_d  = timer_q;
        chk_n_d  = chk_n_q;
        chk_go_d = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        found_d  = found_q;
        last_d   = last_q;
        lo_clamp_s = (lo < TWO_W) ? TWO_W : lo;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    hi_d    = hi;
                    cur_d   = lo_clamp_s;
                    found_d = '0;
                    last_d  = '0;
                    err_d   = 1'b0;
                    if (lo_clamp_s > hi) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        state_d  = S_ISSUE;
                        chk_n_d  = lo_clamp_s;
                        chk_go_d = 1'b1;
                        busy_d   = 1'b1;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (chk_done) begin
                    if (chk_perfect) begin
                        found_d = (found_q == MAX_W) ? found_q : found_q + ONE_W;
                        last_d  = cur_q;
                    end else begin
                        found_d = found_q;
                    end
                    // Compare before incrementing so hi at the top of the range never wraps
                    if (cur_q == hi_q) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cur_d    = cur_q + ONE_W;
                        chk_n_d  = cur_q + ONE_W;
                        chk_go_d = 1'b1;
                        state_d  = S_ISSUE;
                    end
                end else if (timer_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + ONE_T;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            hi_q     <= '0;
            timer_q  <= '0;
            chk_n_q  <= '0;
            chk_go_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            found_q  <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            hi_q     <= hi_d;
            timer_q  <= timer_d;
            chk_n_q  <= chk_n_d;
            chk_go_q <= chk_go_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            found_q  <= found_d;
            last_q   <= last_d;
        end
    end

    assign chk_n      = chk_n_q;
    assign chk_go     = chk_go_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign found_cnt  = found_q;
    assign last_found = last_q;

endmodule

// File: tb/tb_perfect_sweep_sched.sv
// Randomized bench for perfect_sweep_sched with a behavioural checker responder
// and a reference model computed directly from the sweep rules.
module tb_perfect_sweep_sched;

    localparam int W   = 8;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] lo = '0;
    logic [W-1:0] hi = '0;
    logic [W-1:0] chk_n;
    logic         chk_go;
    logic         chk_done;
    logic         chk_perfect;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] found_cnt;
    logic [W-1:0] last_found;

    logic rsp_done = 1'b0, rsp_perf = 1'b0;
    logic man_done = 1'b0, man_perf = 1'b0;
    assign chk_done    = rsp_done | man_done;
    assign chk_perfect = rsp_perf | man_perf;

    int total = 0;
    int bad   = 0;

    int  rsp_lat = 3;
    bit  rsp_on  = 1'b1;
    int  skip_n  = 0;
    bit  pend    = 1'b0;
    int  cnt     = 0;
    int  n_hold  = 0;

    int  issued[$];
    int  done_cnt = 0;
    bit  zero_seen = 1'b0;

    perfect_sweep_sched #(.W(W), .TMO(TMO)) dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort),
        .lo(lo), .hi(hi), .chk_n(chk_n), .chk_go(chk_go),
        .chk_done(chk_done), .chk_perfect(chk_perfect),
        .busy(busy), .done(done), .err(err),
        .found_cnt(found_cnt), .last_found(last_found)
    );

    always #5 clk = ~clk;

    function automatic bit is_perfect(input int n);
        int s;
        s = 0;
        if (n < 2) return 1'b0;
        for (int d = 1; d < n; d++) if (n % d == 0) s += d;
        return (s == n);
    endfunction

    // Behavioural checker: answers each chk_go after rsp_lat cycles
    always @(negedge clk) begin
        rsp_done = 1'b0;
        rsp_perf = 1'b0;
        if (chk_go && rsp_on && int'(chk_n) != skip_n) begin
            pend = 1'b1; cnt = rsp_lat; n_hold = int'(chk_n);
        end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
                pend = 1'b0; rsp_done = 1'b1; rsp_perf = is_perfect(n_hold);
            end
        end
    end

    // Activity monitor
    always @(negedge clk) begin
        if (chk_go) issued.push_back(int'(chk_n));
        if (done) done_cnt++;
        if (busy && chk_n == '0) zero_seen = 1'b1;
    end

    task automatic do_sweep(input int l, input int h, input int lat, input bit tmo);
        int exp_q[$];
        int exp_found, exp_last, exp_cyc, cyc, first;
        bit got;
        first = (l < 2) ? 2 : l;
        for (int n = first; n <= h; n++) exp_q.push_back(n);
        exp_found = 0; exp_last = 0;
        if (tmo) begin
            exp_q = '{first};
            exp_cyc = TMO + 2;
        end else begin
            foreach (exp_q[i]) if (is_perfect(exp_q[i])) begin
                exp_found++; exp_last = exp_q[i];
            end
            if (exp_found > 255) exp_found = 255;
            exp_cyc = exp_q.size() * (1 + lat) + 1;
        end
        rsp_lat = lat; rsp_on = !tmo;
        issued.delete(); done_cnt = 0; zero_seen = 1'b0;
        lo = W'(l); hi = W'(h); start = 1'b1;
        cyc = 0; got = 1'b0;
        while (cyc < 4000 && !got) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                total++;
                if (found_cnt !== 8'd0 || err !== 1'b0) begin
                    bad++; $display("FAIL start_clear lo=%0d hi=%0d found=%0d err=%0d want 0/0", l, h, found_cnt, err);
                end
            end
            if (done) got = 1'b1;
        end
        total++;
        if (!got || cyc != exp_cyc) begin
            bad++; $display("FAIL done_cycle lo=%0d hi=%0d got=%0d cyc=%0d want %0d", l, h, got, cyc, exp_cyc);
        end
        total++;
        if (issued.size() != exp_q.size()) begin
            bad++; $display("FAIL issue_count lo=%0d hi=%0d got %0d want %0d", l, h, issued.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (issued[i] != exp_q[i]) begin
                    bad++; $display("FAIL issue_order idx=%0d got %0d want %0d", i, issued[i], exp_q[i]);
                end
            end
        end
        total++;
        if (found_cnt !== W'(exp_found) || last_found !== W'(exp_last) || err !== tmo || busy !== 1'b0) begin
            bad++; $display("FAIL results lo=%0d hi=%0d found=%0d last=%0d err=%0d busy=%0d want %0d %0d %0d 0",
                            l, h, found_cnt, last_found, err, busy, exp_found, exp_last, tmo);
        end
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt != 1 || zero_seen) begin
            bad++; $display("FAIL done_once lo=%0d hi=%0d done_cnt=%0d zero_seen=%0d want 1 0", l, h, done_cnt, zero_seen);
        end
        rsp_on = 1'b1;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({chk_n, chk_go, busy, done, err, found_cnt, last_found} !== '0) begin
            bad++; $display("FAIL reset_state n=%0d go=%0d busy=%0d done=%0d err=%0d f=%0d l=%0d want all 0",
                            chk_n, chk_go, busy, done, err, found_cnt, last_found);
        end
        clr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_sweep();
        do_sweep(1, 30, 5, 1'b0);
    endtask

    task automatic test_degenerate();
        do_sweep(10, 5, 3, 1'b0);
        do_sweep(0, 1, 3, 1'b0);
        do_sweep(6, 6, 4, 1'b0);
    endtask

    task automatic test_boundary();
        do_sweep(254, 255, 2, 1'b0);
    endtask

    task automatic test_timeout();
        do_sweep(3, 9, 2, 1'b1);
        do_sweep(4, 8, 2, 1'b0);
    endtask

    task automatic test_abort();
        int k, exp_found, exp_last;
        exp_found = 0; exp_last = 0;
        for (int n = 5; n < 12; n++) if (is_perfect(n)) begin exp_found++; exp_last = n; end
        skip_n = 12; rsp_lat = 3; done_cnt = 0;
        lo = 8'd5; hi = 8'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k < 500 && !(chk_go && chk_n == 8'd12)) begin @(negedge clk); k++; end
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++;
        if (k >= 500 || busy !== 1'b0 || chk_go !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL abort_idle k=%0d busy=%0d go=%0d done=%0d want 0 0 0", k, busy, chk_go, done);
        end
        @(negedge clk);
        man_done = 1'b1; man_perf = 1'b1;
        @(negedge clk);
        man_done = 1'b0; man_perf = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (found_cnt !== W'(exp_found) || last_found !== W'(exp_last) || busy !== 1'b0 || done_cnt != 0) begin
            bad++; $display("FAIL abort_late found=%0d last=%0d busy=%0d dones=%0d want %0d %0d 0 0",
                            found_cnt, last_found, busy, done_cnt, exp_found, exp_last);
        end
        skip_n = 0;
    endtask

    task automatic test_reset_mid();
        int k;
        rsp_lat = 4;
        lo = 8'd2; hi = 8'd40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k < 500 && !(chk_go && chk_n == 8'd8)) begin @(negedge clk); k++; end
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        total++;
        if (k >= 500 || {chk_n, chk_go, busy, done, err, found_cnt, last_found} !== '0) begin
            bad++; $display("FAIL reset_mid k=%0d n=%0d go=%0d busy=%0d done=%0d err=%0d f=%0d l=%0d want all 0",
                            k, chk_n, chk_go, busy, done, err, found_cnt, last_found);
        end
        repeat (8) @(negedge clk);
        total++;
        if (busy !== 1'b0 || chk_go !== 1'b0) begin
            bad++; $display("FAIL reset_stays_idle busy=%0d go=%0d want 0 0", busy, chk_go);
        end
        do_sweep(2, 10, 3, 1'b0);
    endtask

    task automatic test_random();
        int l, h, lat;
        for (int i = 0; i < 6; i++) begin
            l = $urandom_range(0, 60);
            h = l + $urandom_range(0, 12) - 2;
            if (h < 0) h = 0;
            lat = $urandom_range(1, 7);
            do_sweep(l, h, lat, 1'b0);
        end
        do_sweep($urandom_range(248, 255), 255, $urandom_range(1, 4), 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_degenerate();
        test_boundary();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perfect_sweep_sched.md
# perfect_sweep_sched

Sequencing controller that drives the perfect-number checker over an inclusive range of N values. It issues one number at a time to the checker and waits for its completion handshake. It counts and records perfect results and reports sweep completion or checker timeout. It sits above the checker controller/datapath pair and is the only agent that starts it.

## Interface
- W, 8, width of N, counters and range bounds
- TMO, 1023, max consecutive WAIT cycles before timeout (≥1)

- clk  in  1  clock, all state changes on rising edge
- clr  in  1  reset, synchronous, active-low
- start  in  1  begin sweep; accepted only in IDLE
- abort  in  1  cancel sweep; return to IDLE
- lo  in  W  lower bound, sampled on accepted start
- hi  in  W  upper bound, sampled on accepted start
- chk_n  out  W  number presented to checker; stable from ISSUE until next ISSUE
- chk_go  out  1  one-cycle start pulse to checker
- chk_done  in  1  one-cycle completion pulse from checker
- chk_perfect  in  1  result; valid only with chk_done
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: sweep finished (normal or timeout)
- err  out  1  timeout flag; sticky until next accepted start or reset
- found_cnt  out  W  perfect numbers found this sweep; saturates at 2^W-1
- last_found  out  W  most recent perfect N this sweep

## Operation
- States: IDLE, ISSUE, WAIT.
- Reset (clr=0 at an edge): state IDLE; every output 0, including chk_n, found_cnt, last_found and err. This overrides all other inputs and applies mid-sweep.
- IDLE with start=1 (abort=0):
  - latch hi; set cur = max(lo, 2); clear found_cnt, last_found and err.
  - If cur > hi: stay IDLE and pulse done next cycle, with no chk_go.
  - Otherwise go to ISSUE.
  - 0 and 1 are never issued.
- ISSUE: chk_go=1 and chk_n=cur for this cycle; clear the timeout timer; go to WAIT.
- WAIT, each cycle:
  - If chk_done=1:
    - If chk_perfect=1: increment found_cnt (hold at max) and set last_found=cur.
    - If cur==hi: go to IDLE and pulse done.
    - Otherwise increment cur and go to ISSUE.
  - If chk_done=0: increment the timer. When TMO WAIT cycles have passed without chk_done, go to IDLE, set err=1 and pulse done.
- cur==hi is compared before increment. hi=2^W-1 therefore ends the sweep with no wrap to 0.
- abort=1 in ISSUE or WAIT: go to IDLE next cycle with no done pulse. Result registers keep their values. abort has priority over chk_done in the same cycle.
- abort in IDLE has no effect. abort=1 together with start=1 in IDLE: start is ignored.
- start while busy: ignored.
- chk_done outside WAIT: ignored, including a late response after abort or timeout.
- found_cnt, last_found and err are readable at any time and stay valid after done until the next accepted start.

## Timing
- start sampled at edge t.
- chk_go is high during cycle t+1 (ISSUE); WAIT begins at cycle t+2.
- chk_done seen at cycle w:
  - non-final N: chk_go is high for the next N in cycle w+1.
  - final N: done is high in cycle w+1 and busy is low from w+1.
- Overhead per N: 2 cycles plus checker latency.
- Empty range: done is high in cycle t+1 and busy stays 0.
- Timeout: WAIT occupies cycles t+2 … t+1+TMO with no chk_done. done=1, err=1 and busy=0 in cycle t+2+TMO.
- abort sampled at edge a: busy=0 and chk_go=0 from cycle a+1.

## Test plan
- Full sweep: lo=1, hi=30, with a behavioral checker of 5-cycle latency that is perfect for 6 and 28. Required: exactly 29 chk_go pulses with chk_n = 2..30 in order, found_cnt=2, last_found=28, err=0, exactly one done pulse.
- Empty and degenerate ranges:
  - lo=10, hi=5: done in cycle t+1, no chk_go, found_cnt=0.
  - lo=0, hi=1: same response as lo=10, hi=5.
  - lo=hi=6: one chk_go with chk_n=6, then found_cnt=1 and last_found=6.
- Boundary no-wrap, W=8: lo=254, hi=255. Required: exactly two issues (254, 255), then done. chk_n never equals 0 after start.
- Timeout, TMO=16, checker never responds: err=1 and done=1 exactly 18 cycles after the start edge, busy=0. A following start clears err.
- Abort and late response: abort during WAIT for N=12 gives busy=0 next cycle and no done. A chk_done=1, chk_perfect=1 two cycles later leaves found_cnt and last_found unchanged.
- Reset mid-sweep: clr=0 for one edge during WAIT. Required: all outputs 0 next cycle and state IDLE. A new start behaves as from power-up.
